t03_dpu_reg_bridge: RTL and testbench

Memory-mapped register bridge between the CPU data bus and the display processing unit (DPU). It accepts CPU word writes/reads in a 16-byte window, holds game-state fields in shadow registers, and commits them to the DPU-facing outputs only at the start of a vertical sync pulse, so a frame is never drawn from a half-updated state. It drives the `gameState`, player state, health, position and facing inputs of the DPU top level.

---
 rtl/t03_dpu_reg_bridge.sv | 190 +++++++++++++++++++
 tb/tb_t03_dpu_reg_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/t03_dpu_reg_bridge.sv
// CPU-to-DPU register bridge: shadow game-state registers committed to the DPU on vsync falling edges.
// Optional build macro T03_DPU_AUTO_COMMIT_EN: commit on every vsync falling edge regardless of pending.
module t03_dpu_reg_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'hFF000000,
  parameter logic [10:0] Y_MAX     = 11'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_write,
  input  logic        bus_read,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic        vsync,
  output logic [2:0]  gameState,
  output logic [1:0]  p1State,
  output logic [1:0]  p2State,
  output logic [3:0]  p1health,
  output logic [3:0]  p2health,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [10:0] x2,
  output logic [10:0] y2,
  output logic        p1Left,
  output logic        p2Left,
  output logic [15:0] frame_count
);

  localparam logic [1:0] REG_POS1 = 2'd0;
  localparam logic [1:0] REG_POS2 = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  logic        in_window;
  logic [1:0]  reg_sel;
  logic        req;
  logic        wr_en;
  logic        rd_en;
  logic [10:0] wr_y;
  logic [31:0] rd_mux;
  logic        unused_bits;

  logic [2:0]  sh_game_state;
  logic [1:0]  sh_p1_state;
  logic [1:0]  sh_p2_state;
  logic [3:0]  sh_p1_health;
  logic [3:0]  sh_p2_health;
  logic [10:0] sh_x1;
  logic [10:0] sh_y1;
  logic [10:0] sh_x2;
  logic [10:0] sh_y2;
  logic        sh_p1_left;
  logic        sh_p2_left;
  logic        pending;

  logic        vsync_prev;
  logic        vsync_fall;
  logic        commit;

  assign in_window = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = bus_addr[3:2];
  assign req       = in_window & (bus_write | bus_read);
  assign wr_en     = in_window & bus_write;
  // a combined read+write performs the write and returns zero data
  assign rd_en     = in_window & bus_read & ~bus_write;
  assign wr_y      = (bus_wdata[26:16] > Y_MAX) ? Y_MAX : bus_wdata[26:16];

  assign unused_bits = ^{bus_wdata[31:27], bus_wdata[15:11]};

`ifdef T03_DPU_AUTO_COMMIT_EN
  assign commit = vsync_fall;
`else
  assign commit = vsync_fall & pending;
`endif

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      REG_POS1: rd_mux = {5'd0, sh_y1, 5'd0, sh_x1};
      REG_POS2: rd_mux = {5'd0, sh_y2, 5'd0, sh_x2};
      REG_STAT: rd_mux = {8'd0, sh_p2_health, sh_p1_health, 6'd0, sh_p2_left, sh_p1_left,
                          sh_p2_state, sh_p1_state, 1'b0, sh_game_state};
      REG_CTRL: rd_mux = {frame_count, 15'd0, pending};
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= 32'd0;
    end else begin
      bus_ack   <= req;
      bus_rdata <= rd_en ? rd_mux : 32'd0;
    end
  end

  // one registered stage after the previous-vsync compare gives the edge its cycle of latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_prev  <= 1'b1;
      vsync_fall  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      vsync_prev <= vsync;
      vsync_fall <= vsync_prev & ~vsync;
      if (vsync_fall) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_x1         <= 11'd0;
      sh_y1         <= 11'd0;
      sh_x2         <= 11'd0;
      sh_y2         <= 11'd0;
      sh_game_state <= 3'd0;
      sh_p1_state   <= 2'd0;
      sh_p2_state   <= 2'd0;
      sh_p1_left    <= 1'b0;
      sh_p2_left    <= 1'b0;
      sh_p1_health  <= 4'd9;
      sh_p2_health  <= 4'd9;
    end else if (wr_en) begin
      case (reg_sel)
        REG_POS1: begin
          sh_x1 <= bus_wdata[10:0];
          sh_y1 <= wr_y;
        end
        REG_POS2: begin
          sh_x2 <= bus_wdata[10:0];
          sh_y2 <= wr_y;
        end
        REG_STAT: begin
          sh_game_state <= bus_wdata[2:0];
          sh_p1_state   <= bus_wdata[5:4];
          sh_p2_state   <= bus_wdata[7:6];
          sh_p1_left    <= bus_wdata[8];
          sh_p2_left    <= bus_wdata[9];
          sh_p1_health  <= bus_wdata[19:16];
          sh_p2_health  <= bus_wdata[23:20];
        end
        default: ;
      endcase
    end
  end

  // a CTRL set in the edge cycle wins over the clear so it carries into the next frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (wr_en && (reg_sel == REG_CTRL) && bus_wdata[0]) begin
      pending <= 1'b1;
    end else if (vsync_fall) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1        <= 11'd0;
      y1        <= 11'd0;
      x2        <= 11'd0;
      y2        <= 11'd0;
      gameState <= 3'd0;
      p1State   <= 2'd0;
      p2State   <= 2'd0;
      p1Left    <= 1'b0;
      p2Left    <= 1'b0;
      p1health  <= 4'd9;
      p2health  <= 4'd9;
    end else if (commit) begin
      x1        <= sh_x1;
      y1        <= sh_y1;
      x2        <= sh_x2;
      y2        <= sh_y2;
      gameState <= sh_game_state;
      p1State   <= sh_p1_state;
      p2State   <= sh_p2_state;
      p1Left    <= sh_p1_left;
      p2Left    <= sh_p2_left;
      p1health  <= sh_p1_health;
      p2health  <= sh_p2_health;
    end
  end

endmodule

// File: tb/tb_t03_dpu_reg_bridge.sv
// Directed bench for t03_dpu_reg_bridge; expectations follow T03_DPU_AUTO_COMMIT_EN when defined.
module tb_t03_dpu_reg_bridge;

`ifdef T03_DPU_AUTO_COMMIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_write;
  logic        bus_read;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        vsync;
  logic [2:0]  gameState;
  logic [1:0]  p1State, p2State;
  logic [3:0]  p1health, p2health;
  logic [10:0] x1, y1, x2, y2;
  logic        p1Left, p2Left;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        ak;

  t03_dpu_reg_bridge dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_read(bus_read),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .vsync(vsync),
    .gameState(gameState), .p1State(p1State), .p2State(p2State),
    .p1health(p1health), .p2health(p2health),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .p1Left(p1Left), .p2Left(p2Left), .frame_count(frame_count)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                        output logic [31:0] rdata, output logic ack);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_write = w; bus_read = r;
    @(negedge clk);
    bus_write = 1'b0; bus_read = 1'b0;
    ack = bus_ack; rdata = bus_rdata;
  endtask

  task automatic vpulse();
    @(negedge clk); vsync = 1'b0;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // write lands in the same cycle the detected edge acts
  task automatic vpulse_with_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); vsync = 1'b0;
    @(negedge clk); vsync = 1'b1;
    bus_addr = a; bus_wdata = d; bus_write = 1'b1;
    @(negedge clk); bus_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; vsync = 1'b1;
    bus_addr = 32'd0; bus_wdata = 32'd0; bus_write = 1'b0; bus_read = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("rst_gs", gameState, 0);
    check("rst_x1", x1, 0);
    check("rst_y2", y2, 0);
    check("rst_p1h", p1health, 9);
    check("rst_p2h", p2health, 9);
    check("rst_fc", frame_count, 0);
    check("rst_ack", bus_ack, 0);

    bus_op(32'hFF000008, 0, 1'b0, 1'b1, rd, ak);
    check("stat_rst_ack", ak, 1);
    check("stat_rst_rd", rd, 32'h00990000);
    @(negedge clk);
    check("ack_one_cycle", bus_ack, 0);
    check("rdata_idle", bus_rdata, 0);

    bus_op(32'hFF000000, 32'h01F40064, 1'b1, 1'b0, rd, ak);
    check("wr_pos1_ack", ak, 1);
    check("wr_pos1_rd0", rd, 0);
    bus_op(32'hFF000008, 32'h00350321, 1'b1, 1'b0, rd, ak);
    bus_op(32'hFF000000, 0, 1'b0, 1'b1, rd, ak);
    check("rd_pos1", rd, 32'h01F40064);
    bus_op(32'hFF000008, 0, 1'b0, 1'b1, rd, ak);
    check("rd_stat", rd, 32'h00350321);

    vpulse();
    check("nopend_x1", x1, AUTO ? 100 : 0);
    check("nopend_gs", gameState, AUTO ? 1 : 0);
    check("nopend_fc", frame_count, 1);

    bus_op(32'hFF00000C, 1, 1'b1, 1'b0, rd, ak);
    bus_op(32'hFF00000C, 0, 1'b0, 1'b1, rd, ak);
    check("ctrl_pend", rd, 32'h00010001);
    vpulse();
    check("c1_x1", x1, 100);
    check("c1_y1", y1, 500);
    check("c1_gs", gameState, 1);
    check("c1_p1s", p1State, 2);
    check("c1_p2s", p2State, 0);
    check("c1_p1l", p1Left, 1);
    check("c1_p2l", p2Left, 1);
    check("c1_p1h", p1health, 5);
    check("c1_p2h", p2health, 3);
    check("c1_fc", frame_count, 2);
    bus_op(32'hFF00000C, 0, 1'b0, 1'b1, rd, ak);
    check("ctrl_clr", rd, 32'h00020000);

    bus_op(32'hFF000004, 32'h07FF0123, 1'b1, 1'b0, rd, ak);
    bus_op(32'hFF000004, 0, 1'b0, 1'b1, rd, ak);
    check("rd_pos2_clamp", rd, 32'h01F40123);
    bus_op(32'hFF00000C, 1, 1'b1, 1'b0, rd, ak);
    vpulse();
    check("c2_y2", y2, 500);
    check("c2_x2", x2, 11'h123);

    bus_op(32'hFF000000, 32'h00100020, 1'b1, 1'b0, rd, ak);
    vpulse_with_write(32'hFF00000C, 1);
    check("ctrl_edge_x1", x1, AUTO ? 32 : 100);
    bus_op(32'hFF00000C, 0, 1'b0, 1'b1, rd, ak);
    check("ctrl_edge_pend", rd, 32'h00040001);
    vpulse();
    check("ctrl_next_x1", x1, 32);
    check("ctrl_next_y1", y1, 16);

    bus_op(32'hFF000000, 32'h00050006, 1'b1, 1'b0, rd, ak);
    bus_op(32'hFF00000C, 1, 1'b1, 1'b0, rd, ak);
    vpulse_with_write(32'hFF000000, 32'h00070008);
    check("pos_edge_x1", x1, 6);
    check("pos_edge_y1", y1, 5);
    bus_op(32'hFF00000C, 1, 1'b1, 1'b0, rd, ak);
    vpulse();
    check("pos_next_x1", x1, 8);
    check("pos_next_y1", y1, 7);
    check("fc7", frame_count, 7);

    bus_op(32'hFF000010, 32'h00000001, 1'b1, 1'b0, rd, ak);
    check("oow_hi_ack", ak, 0);
    bus_op(32'hFE000000, 32'h11112222, 1'b1, 1'b0, rd, ak);
    check("oow_lo_ack", ak, 0);
    bus_op(32'hFF000010, 0, 1'b0, 1'b1, rd, ak);
    check("oow_rd_ack", ak, 0);
    check("oow_rd_data", rd, 0);
    bus_op(32'hFF000000, 0, 1'b0, 1'b1, rd, ak);
    check("oow_pos1", rd, 32'h00070008);

    bus_op(32'hFF000000, 32'h00AA00BB, 1'b1, 1'b1, rd, ak);
    check("rw_ack", ak, 1);
    check("rw_rd", rd, 0);
    bus_op(32'hFF000003, 0, 1'b0, 1'b1, rd, ak);
    check("rw_pos1_lowbits", rd, 32'h00AA00BB);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); vsync = 1'b0;
      @(negedge clk); vsync = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    check("bulk_fc", frame_count, 1007);
    check("bulk_x1", x1, AUTO ? 32'hBB : 8);
    bus_op(32'hFF00000C, 0, 1'b0, 1'b1, rd, ak);
    check("bulk_ctrl", rd, 32'h03EF0000);

    bus_op(32'hFF000004, 32'h00010002, 1'b1, 1'b0, rd, ak);
    vpulse();
    check("auto_x2", x2, AUTO ? 2 : 11'h123);
    check("auto_fc", frame_count, 1008);

    @(negedge clk);
    bus_addr = 32'hFF000008; bus_read = 1'b1;
    @(posedge clk);
    #10 rst = 1'b0; bus_read = 1'b0;
    #5;
    check("midrst_ack", bus_ack, 0);
    check("midrst_rd", bus_rdata, 0);
    check("midrst_fc", frame_count, 0);
    check("midrst_x1", x1, 0);
    check("midrst_p1h", p1health, 9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ack", bus_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
